// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (read-only) and data (read/write).
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic              timeout_err_q, timeout_err_d;

    logic              pick_data;
    logic [DATA_W-1:0] finish_data;

    // Which requester wins when the arbiter is free; only meaningful if some request is pending.
    always_comb begin
        pick_data = d_req;
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) begin
            pick_data = (last_grant_q == OWN_IF);
        end
`endif
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ready_d    = 1'b0;
        d_ready_d     = 1'b0;
        timeout_err_d = 1'b0;
        finish_data   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    state_d  = ST_ACCESS;
                    mem_en_d = 1'b1;
                    cnt_d    = '0;
                    if (pick_data) begin
                        owner_d      = OWN_D;
                        last_grant_d = OWN_D;
                        mem_we_d     = d_we;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                    end else begin
                        owner_d      = OWN_IF;
                        last_grant_d = OWN_IF;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                    end
                end
            end

            ST_ACCESS: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    if (mem_ack) begin
                        finish_data = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        finish_data   = ERR_DATA;
                        timeout_err_d = 1'b1;
                    end
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = finish_data;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = finish_data;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_IF;
            last_grant_q  <= OWN_IF;
            cnt_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            d_rdata_q     <= '0;
            d_ready_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            if_ready_q    <= if_ready_d;
            d_rdata_q     <= d_rdata_d;
            d_ready_q     <= d_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses, arbitration ties,
// reset mid-access and stray acks, with a scoreboard of expected completions.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 8;
    localparam int MAX_WAIT = 40;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;     // ACCESS cycle that carries mem_ack; 0 = never
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
        logic        exp_tmo;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] exp_grants[$];
    vec_t        vecs[8];

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Scoreboard consumer: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (if_ready || d_ready)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 64'({if_ready, d_ready}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("ready_owner", 64'({if_ready, d_ready}), e.is_data ? 64'd1 : 64'd2);
                check("ready_rdata", 64'(e.is_data ? d_rdata : if_rdata), 64'(e.rdata));
                check("ready_timeout_err", 64'(timeout_err), 64'(e.tmo));
            end
        end
        if (timeout_err && !(if_ready || d_ready)) begin
            check("stray_timeout_err", 64'd1, 64'd0);
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int   acc = 0;
        int   lat = 0;
        bit   done = 1'b0;
        bit   field_bad = 1'b0;
        exp_t e;
        e.is_data = v.is_data;
        e.rdata   = v.exp_rdata;
        e.tmo     = v.exp_tmo;
        sb_q.push_back(e);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            if_addr = 32'hFFFF_FFF0;
        end else begin
            // Junk on the data side must not leak into a fetch.
            if_req = 1'b1; if_addr = v.addr;
            d_we = 1'b1; d_addr = 32'hFFFF_FFFC; d_wdata = 32'hBAD0_BAD0;
        end
        while (!done && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
            if (if_ready || d_ready) begin
                done = 1'b1;
            end else if (mem_en) begin
                acc++;
                if (mem_we !== (v.is_data & v.we) || mem_addr !== v.addr ||
                    (v.is_data && v.we && mem_wdata !== v.wdata)) begin
                    field_bad = 1'b1;
                end
                if (acc == v.ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.mem_data;
                end
            end
        end
        if (!done) sb_q.delete(sb_q.size() - 1);
        check({tag, "_ready_seen"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'((v.ack_at == 0) ? TIMEOUT + 1 : v.ack_at + 1));
        check({tag, "_access_cycles"}, 64'(acc), 64'((v.ack_at == 0) ? TIMEOUT : v.ack_at));
        check({tag, "_mem_fields"}, 64'(field_bad), 64'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, 64'({mem_en, if_ready, d_ready, timeout_err}), 64'd0);
        check({tag, "_rdata_hold"}, 64'(v.is_data ? d_rdata : if_rdata), 64'(v.exp_rdata));
    endtask

    // Both requesters pending with immediate acks; optionally re-raise whichever just completed.
    task automatic tie_run(input int n, input bit reraise, input string tag);
        int readys = 0;
        int cyc    = 0;
        bit re_d   = 1'b0;
        bit re_f   = 1'b0;
        grant_log.delete();
        if_addr = 32'h14; d_addr = 32'h80; d_we = 1'b0; d_wdata = '0;
        if_req = 1'b1; d_req = 1'b1;
        while (readys < n && cyc < MAX_WAIT * n) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (re_d) begin d_req = 1'b1; re_d = 1'b0; end
            if (re_f) begin if_req = 1'b1; re_f = 1'b0; end
            if (mem_en) begin
                grant_log.push_back(mem_addr);
                mem_ack   = 1'b1;
                mem_rdata = rd_of(mem_addr);
            end
            if (d_ready) begin d_req = 1'b0; readys++; re_d = reraise; end
            if (if_ready) begin if_req = 1'b0; readys++; re_f = reraise; end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check({tag, "_readys"}, 64'(readys), 64'(n));
        check({tag, "_grant_count"}, 64'(grant_log.size()), 64'(exp_grants.size()));
        for (int i = 0; i < exp_grants.size() && i < grant_log.size(); i++) begin
            check($sformatf("%s_grant%0d", tag, i), 64'(grant_log[i]), 64'(exp_grants[i]));
        end
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_data);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rd_of(is_data ? 32'h80 : 32'h14);
        e.tmo     = 1'b0;
        sb_q.push_back(e);
        exp_grants.push_back(is_data ? 32'h80 : 32'h14);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t post_rst;

        //          is_data we    addr       wdata          ack mem_data       exp_rdata      tmo
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0000_0000, 1, 32'h8C01_0004, 32'h8C01_0004, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h80, 32'h0000_0000, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h40, 32'h1234_5678, 4, 32'h5555_5555, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h14, 32'h0000_0000, 3, 32'h0000_0013, 32'h0000_0013, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h20, 32'h0000_0000, 0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h44, 32'hA5A5_A5A5, 8, 32'h7777_7777, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h48, 32'h0000_0000, 0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h4C, 32'h0000_0000, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({if_ready, d_ready, mem_en, mem_we, timeout_err}), 64'd0);
        check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("rst_mem", 64'({mem_addr, mem_wdata}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray ack with nothing outstanding must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        check("stray_ack_1", 64'({mem_en, if_ready, d_ready, timeout_err}), 64'd0);
        @(negedge clk);
        check("stray_ack_2", 64'({mem_en, if_ready, d_ready, timeout_err}), 64'd0);
        mem_ack = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // After reset last_grant is fetch, so the first tie goes to data in either build.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_grants.delete();
        push_exp(1'b1);
        push_exp(1'b0);
        tie_run(2, 1'b0, "tie_once");

        exp_grants.delete();
`ifdef MEM_ARB_RR_EN
        push_exp(1'b1); push_exp(1'b0); push_exp(1'b1); push_exp(1'b0);
`else
        push_exp(1'b1); push_exp(1'b1); push_exp(1'b1); push_exp(1'b1);
`endif
        tie_run(4, 1'b1, "tie_repeat");

        // Reset during the second ACCESS cycle aborts silently.
        d_addr = 32'h90; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        check("rma_access1", 64'(mem_en), 64'd1);
        @(negedge clk);
        check("rma_access2", 64'(mem_en), 64'd1);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check("rma_ctrl", 64'({if_ready, d_ready, mem_en, mem_we, timeout_err}), 64'd0);
        check("rma_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("rma_mem", 64'({mem_addr, mem_wdata}), 64'd0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rma_late_ack", 64'({mem_en, if_ready, d_ready, timeout_err}), 64'd0);
        @(negedge clk);
        check("rma_quiet", 64'({mem_en, if_ready, d_ready, d_rdata}), 64'd0);

        post_rst = '{1'b1, 1'b0, 32'hA0, 32'h0, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0};
        run_vec(post_rst, "post_rst");

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
